// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller over a req/ack data-memory handshake.
// Define MEM_TIMEOUT_EN to add the WAIT timeout counter and bus_fault pulse.
module mem_access_unit
`ifdef MEM_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mem_read,
    input  logic [2:0]  mem_write,
    input  logic [31:0] alu_result,
    input  logic [31:0] read_data2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] load_data,
    output logic        mem_stall,
`ifdef MEM_TIMEOUT_EN
    output logic        misaligned,
    output logic        bus_fault
`else
    output logic        misaligned
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [31:0] load_q;

    logic        access, is_st, half, word;
    logic [1:0]  size, off;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        start, capture, abort;

    assign is_st  = mem_write[2];
    assign access = mem_read[3] | is_st;
    assign size   = is_st ? mem_write[1:0] : mem_read[1:0];
    assign off    = alu_result[1:0];
    assign half   = (size == 2'b01);
    assign word   = size[1];

    assign misaligned = access & ((half & off[0]) | (word & (off != 2'b00)));

    always_comb begin
        be_c    = 4'b0001 << off;
        wdata_c = {4{read_data2[7:0]}};
        unique case (1'b1)
            word: begin
                be_c    = 4'b1111;
                wdata_c = read_data2;
            end
            half: begin
                be_c    = 4'b0011 << off;
                wdata_c = {2{read_data2[15:0]}};
            end
            default: ;
        endcase
    end

    // Extraction uses the lane offset latched at request time.
    logic [31:0] rd_b, rd_h, ext;
    assign rd_b = dmem_rdata >> {off_q, 3'b000};
    assign rd_h = dmem_rdata >> {off_q[1], 4'b0000};

    always_comb begin
        ext = dmem_rdata;
        unique case (f3_q[1:0])
            2'b00:   ext = f3_q[2] ? {24'd0, rd_b[7:0]}
                                   : {{24{rd_b[7]}}, rd_b[7:0]};
            2'b01:   ext = f3_q[2] ? {16'd0, rd_h[15:0]}
                                   : {{16{rd_h[15]}}, rd_h[15:0]};
            default: ext = dmem_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          fault_q;
`endif

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: if (access && !misaligned) begin
                state_d = WAIT;
                start   = 1'b1;
            end
            WAIT: if (dmem_ack) begin
                state_d = DONE;
                capture = ~we_q;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                state_d = DONE;
                abort   = 1'b1;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            off_q   <= 2'd0;
            f3_q    <= 3'd0;
            load_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (start) begin
                we_q    <= is_st;
                addr_q  <= {alu_result[31:2], 2'b00};
                be_q    <= be_c;
                wdata_q <= wdata_c;
                off_q   <= off;
                f3_q    <= mem_read[2:0];
            end
            if (capture)
                load_q <= ext;
            else if (abort && !we_q)
                load_q <= 32'd0;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= abort;
            if (start)
                cnt_q <= '0;
            else if (state_q == WAIT)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus_fault = fault_q;
`endif

    assign dmem_req   = (state_q == WAIT);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign load_data  = load_q;
    assign mem_stall  = ((state_q == IDLE) & access & ~misaligned)
                      | (state_q == WAIT);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + random bench for mem_access_unit against a behavioural model.
// Build with MEM_TIMEOUT_EN defined to also exercise the timeout path.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_read;
    logic [2:0]  mem_write;
    logic [31:0] alu_result, read_data2;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data;
    logic [3:0]  dmem_be;
    logic        dmem_ack, mem_stall, misaligned;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_ld = 32'd0;

    always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
    logic bus_fault;
    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .alu_result(alu_result), .read_data2(read_data2),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .load_data(load_data),
        .mem_stall(mem_stall), .misaligned(misaligned),
        .bus_fault(bus_fault)
    );
`else
    localparam int TO = 1000;
    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .alu_result(alu_result), .read_data2(read_data2),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .load_data(load_data),
        .mem_stall(mem_stall), .misaligned(misaligned)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_be(input int sz, input int off);
        if (sz >= 2) return 32'd15;
        if (sz == 1) return 32'(3 * (1 << off));
        return 32'(1 << off);
    endfunction

    function automatic logic [31:0] m_wdata(input int sz,
                                            input logic [31:0] d);
        if (sz >= 2) return d;
        if (sz == 1) return (d % 65536) * 32'h0001_0001;
        return (d % 256) * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] m_load(input int f3, input int off,
                                           input logic [31:0] r);
        logic [31:0] v;
        case (f3 % 4)
            0: begin
                v = (r >> (8 * off)) % 256;
                if (f3 == 0 && v >= 128) v = v - 256;
            end
            1: begin
                v = (r >> (16 * (off / 2))) % 65536;
                if (f3 == 1 && v >= 32768) v = v - 65536;
            end
            default: v = r;
        endcase
        return v;
    endfunction

    // One instruction presented in IDLE; dly=0 means memory never acks.
    task automatic do_access(input logic [3:0] mr, input logic [2:0] mw,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] rd, input int dly);
        bit st, acc, mis, ld, tmo;
        int sz, off, w;
        logic [31:0] wexp;
        mem_read = mr; mem_write = mw; alu_result = a; read_data2 = d;
        st  = mw[2];
        ld  = mr[3] && !st;
        acc = mr[3] || st;
        sz  = st ? int'(mw[1:0]) : int'(mr[1:0]);
        off = int'(a % 4);
        mis = acc && ((sz == 1 && off % 2 == 1) || (sz >= 2 && off != 0));
        @(negedge clk);
        chk("misaligned", 32'(misaligned), 32'(mis));
        chk("stall_idle", 32'(mem_stall), 32'(acc && !mis));
        if (!acc || mis) begin
            dmem_ack = 1'b1; dmem_rdata = $urandom;
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            chk("no_req", 32'(dmem_req), 32'd0);
            chk("ld_hold", load_data, exp_ld);
            mem_read = '0; mem_write = '0;
            return;
        end
        @(posedge clk); #1;
        tmo = 1'b0;
        wexp = m_wdata(sz, d);
        for (w = 1; w <= 64; w++) begin
            dmem_ack = (w == dly);
            dmem_rdata = (w == dly) ? rd : $urandom;
            @(negedge clk);
            chk("req", 32'(dmem_req), 32'd1);
            chk("stall_wait", 32'(mem_stall), 32'd1);
            chk("we", 32'(dmem_we), 32'(st));
            chk("addr", dmem_addr, a - (a % 4));
            chk("be", 32'(dmem_be), m_be(sz, off));
            if (st) chk("wdata", dmem_wdata, wexp);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            if (w == dly) break;
            if (w == TO) begin tmo = 1'b1; break; end
        end
        if (w > 64) chk("ack_bound", 32'd1, 32'd0);
        if (ld) exp_ld = tmo ? 32'd0 : m_load(int'(mr[2:0]), off, rd);
        @(negedge clk);
        chk("done_stall", 32'(mem_stall), 32'd0);
        chk("done_req", 32'(dmem_req), 32'd0);
        chk("load_data", load_data, exp_ld);
`ifdef MEM_TIMEOUT_EN
        chk("bus_fault", 32'(bus_fault), 32'(tmo));
`endif
        @(posedge clk); #1;
        mem_read = '0; mem_write = '0;
    endtask

    initial begin
        logic [3:0] mr;
        logic [2:0] mw;
        int f3s[5] = '{0, 1, 2, 4, 5};
        rst = 1'b0;
        mem_read = '0; mem_write = '0; alu_result = '0; read_data2 = '0;
        dmem_rdata = '0; dmem_ack = 1'b0;
        #2;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_ld", load_data, 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
`ifdef MEM_TIMEOUT_EN
        chk("rst_fault", 32'(bus_fault), 32'd0);
`endif
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        do_access(4'b1010, 3'b000, 32'h10, 32'h0, 32'hDEADBEEF, 3);
        do_access(4'b1000, 3'b000, 32'h13, 32'h0, 32'h80FF_1234, 1);
        chk("lb_val", load_data, 32'hFFFF_FF80);
        do_access(4'b1100, 3'b000, 32'h13, 32'h0, 32'h80FF_1234, 2);
        chk("lbu_val", load_data, 32'h0000_0080);
        do_access(4'b0000, 3'b101, 32'h22, 32'hABCD, 32'h0, 1);
        do_access(4'b1010, 3'b000, 32'h6, 32'h0, 32'h0, 1);
        do_access(4'b0000, 3'b000, 32'h44, 32'h0, 32'h0, 1);

        mem_read = 4'b1010; alu_result = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_read = '0;
        #1;
        chk("rstw_req", 32'(dmem_req), 32'd0);
        chk("rstw_ld", load_data, 32'd0);
        chk("rstw_stall", 32'(mem_stall), 32'd0);
        exp_ld = 32'd0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        do_access(4'b0000, 3'b110, 32'h80, 32'h1234_5678, 32'h0, 2);

`ifdef MEM_TIMEOUT_EN
        do_access(4'b1010, 3'b000, 32'h100, 32'h0, 32'h0, 0);
`endif

        for (int i = 0; i < 60; i++) begin
            mr = '0; mw = '0;
            case ($urandom_range(0, 4))
                0, 1: mr = {1'b1, 3'(f3s[$urandom_range(0, 4)])};
                2:    mw = {1'b1, 2'($urandom_range(0, 2))};
                3: begin
                    mr = {1'b1, 3'(f3s[$urandom_range(0, 4)])};
                    mw = {1'b1, 2'($urandom_range(0, 2))};
                end
                default: ;
            endcase
            do_access(mr, mw, $urandom, $urandom, $urandom,
                      $urandom_range(1, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage controller that consumes the EX/MEM pipeline register outputs and performs loads and stores against a multi-cycle data memory over a req/ack handshake. It generates byte enables and store-data lane placement, sign/zero-extends load data, and stalls the pipeline until the access completes. Its outputs feed the MEM/WB pipeline register and the hazard unit.

## Interface
- TIMEOUT_CYCLES, 16, maximum WAIT cycles before abort; used only with MEM_TIMEOUT_EN.
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_read  input  4  load control. Bit3 enables the load. Bits[2:0] give the funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_write  input  3  store control. Bit2 enables the store. Bits[1:0]: 00 SB, 01 SH, 10 SW.
- alu_result  input  32  effective byte address.
- read_data2  input  32  store data, right-aligned.
- dmem_req  output  1  access request to data memory.
- dmem_we  output  1  1 selects write, 0 selects read.
- dmem_addr  output  32  word address, equal to {alu_result[31:2], 2'b00}.
- dmem_be  output  4  byte enables.
- dmem_wdata  output  32  store data shifted into the addressed lanes.
- dmem_rdata  input  32  read word, valid while dmem_ack=1.
- dmem_ack  input  1  access complete.
- load_data  output  32  extended load result, registered.
- mem_stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- misaligned  output  1  misaligned access detected, combinational.
- bus_fault  output  1  one-cycle pulse when an access times out; exists only with MEM_TIMEOUT_EN.

## Operation
- The FSM has three states: IDLE, WAIT, DONE. It resets to IDLE.
- access = mem_read[3] | mem_write[2]. If both are set, the store takes priority.
- misaligned = access & ((halfword & alu_result[0]) | (word & alu_result[1:0]≠0)).
- IDLE:
  - access & !misaligned: go to WAIT and latch address, we, be and wdata into the request registers.
  - misaligned: stay in IDLE. Issue no request and no stall; the instruction passes with load_data unchanged.
- WAIT:
  - dmem_req=1, with dmem_we/addr/be/wdata held stable from the request registers.
  - On a clock edge with dmem_ack=1: for a load, capture dmem_rdata into load_data after extraction and extension; go to DONE.
- DONE: lasts one cycle with mem_stall=0, so the pipeline advances. Return to IDLE.
- mem_stall = (IDLE & access & !misaligned) | WAIT.
- Byte enables:
  - SB/LB/LBU: 1 << addr[1:0].
  - SH/LH/LHU: 0011 << addr[1:0].
  - SW/LW: 1111.
- Store data placement:
  - SB: byte replicated ×4.
  - SH: halfword replicated ×2.
  - SW: as is.
- Load extraction: select the byte or halfword by addr[1:0], then sign-extend (LB, LH) or zero-extend (LBU, LHU). LW passes the word through.
- dmem_ack outside WAIT is ignored.
- load_data holds its value except on a load capture.

## Timing
- Reset values: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, load_data=0, bus_fault=0. mem_stall follows its equation (0 when inputs are idle).
- Reset asserted mid-WAIT drops dmem_req asynchronously and abandons the access.
- Latency: access presented in cycle N → dmem_req high from N+1. If ack arrives in cycle N+k (k≥1), DONE is cycle N+k+1 and load_data is valid from N+k+1.
- The minimum cost is 2 stall cycles per memory instruction.
- Non-memory instructions incur 0 stall cycles.
- Back-to-back memory instructions: the second is seen in IDLE the cycle after DONE.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no ack: deassert dmem_req, pulse bus_fault for one cycle, set load_data=0 for loads, and go to DONE.
  - A late ack arriving after the abort is ignored.
- MEM_TIMEOUT_EN undefined: no counter and no bus_fault port. WAIT waits indefinitely for dmem_ack.

## Test plan
- LW at 0x0000_0010; memory acks 3 cycles after req with 0xDEADBEEF → dmem_be=1111, addr=0x10; load_data=0xDEADBEEF in DONE; mem_stall high for 4 cycles.
- LB at 0x13 and LBU at 0x13, rdata=0x80FF_1234 → load_data=0xFFFF_FF80 for LB and 0x0000_0080 for LBU; be=1000 for both.
- SH of 0x0000_ABCD at 0x22 → dmem_we=1, be=1100, wdata=0xABCD_ABCD, addr=0x20; load_data unchanged.
- LW at 0x0000_0006 → misaligned=1, dmem_req stays 0, mem_stall=0.
- Reset pulled low while in WAIT → dmem_req=0 immediately. After release: state IDLE, load_data=0, and a new SW completes normally.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, LW with ack never asserted → bus_fault pulses after 4 WAIT cycles, then load_data=0 and mem_stall=0 in DONE.
